booth_vote_scheduler: RTL
=========================

BOOTH_VOTE_SCHEDULER -- requirements
Module: booth_vote_scheduler

Interface
REQ-001 SHALL have parameter NUM_BOOTHS, default 4, meaning number of requesting booths; fixed at 4 in this revision.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port open_req  input  1  one-cycle pulse that opens a voting session.
REQ-005 SHALL have port close_req  input  1  one-cycle pulse that closes the session.
REQ-006 SHALL have port booth_req  input  4  per-booth level, held until that booth's ack or nack.
REQ-007 SHALL have port booth_choice  input  8  2 bits per booth (booth i at [2i+1:2i]); 00=A, 01=B, 10=C, 11=invalid.
REQ-008 SHALL have port booth_ack  output  4  one-cycle pulse: vote delivered to tally.
REQ-009 SHALL have port booth_nack  output  4  one-cycle pulse: request rejected.
REQ-010 SHALL have ports cast_valid  output  1, cast_choice  output  2 and cast_booth  output  2, forming the vote stream to the tally counter.
REQ-011 SHALL have port cast_ready  input  1  tally accepts the vote.
REQ-012 SHALL have ports state_out  output  2, voted_mask  output  4, total_votes  output  8 and reject_count  output  8.

Function
REQ-013 SHALL implement an FSM with states IDLE=00, OPEN=01, DRAIN=10, CLOSED=11, and SHALL drive state_out with the current state.
REQ-014 SHALL take these transitions: IDLE/CLOSED->OPEN on open_req; OPEN->DRAIN on close_req (close wins over a simultaneous open); DRAIN->CLOSED in the first cycle with cast_valid=0; otherwise hold.
REQ-015 SHALL, on entry to OPEN, clear voted_mask, total_votes and reject_count.
REQ-016 SHALL exclude from selection any booth whose ack or nack pulsed in the previous cycle (one-cycle cooldown).
REQ-017 SHALL select at most one booth per cycle from the remaining requesters, round-robin, starting after the last selected booth; the pointer resets to booth 0.
REQ-018 SHALL make no selection while cast_valid=1.
REQ-019 SHALL treat the selected booth as eligible only if state=OPEN, its voted_mask bit is 0 and its choice is not 11.
REQ-020 SHALL, for an eligible selected booth, register cast_valid=1 with its cast_choice and cast_booth the next cycle, and hold them stable until cast_valid&&cast_ready.
REQ-021 SHALL, in the cycle after a cast_valid&&cast_ready handshake, drop cast_valid (unless a new cast launches), pulse booth_ack for that booth, set its voted_mask bit and increment total_votes, saturating at 255.
REQ-022 SHALL, for an ineligible selected booth, pulse booth_nack the next cycle and increment reject_count, saturating at 255; voted_mask is unchanged.
REQ-023 SHALL never have more than one ack or nack bit set per cycle, and ack and nack SHALL never be set together.
REQ-024 SHALL keep an in-flight cast alive through DRAIN until cast_ready, acking it normally.
REQ-025 SHALL have all outputs registered except state_out (combinational from state).

Reset
REQ-026 SHALL, with rst_n low, immediately set: state=IDLE, cast_valid=0, cast_choice=0, cast_booth=0, booth_ack=0, booth_nack=0, voted_mask=0, total_votes=0, reject_count=0, RR pointer=0.
REQ-027 SHALL abandon a mid-handshake vote on reset, with no ack and no count; operation resumes on the first clock edge after rst_n rises.

Structure
REQ-028 SHALL take the FSM state encodings, the choice codes (A, B, C, INVALID) and NUM_BOOTHS from a shared package, voting_pkg.
REQ-029 SHALL implement round-robin selection in a sub-module rr_arbiter_4 (inputs req[3:0], advance; outputs grant one-hot, grant_idx).

Verification
REQ-030 SHALL verify: open_req, booth 2 requests choice 01, cast_ready=1 -> cast_valid with cast_booth=2 and cast_choice=01 one cycle later, booth_ack[2] the following cycle, voted_mask=0100, total_votes=1.
REQ-031 SHALL verify: all 4 booths request together, cast_ready=1 -> casts appear in order booth 0,1,2,3, one ack per booth, total_votes=4.
REQ-032 SHALL verify: booth 1 votes, then requests again -> booth_nack[1], reject_count=1, total_votes unchanged; choice 11 from booth 3 -> nack, reject_count=2.
REQ-033 SHALL verify: cast pending with cast_ready=0 for 5 cycles and close_req issued -> state DRAIN, cast fields stable, then cast_ready=1 -> ack, then CLOSED.
REQ-034 SHALL verify: a request while IDLE -> nack; rst_n low during cast_valid=1 -> all outputs zero asynchronously and no ack.
REQ-035 SHALL verify: 256 accepted votes across sessions without reopening (bench forces cycling) -> total_votes saturates at 255.

Source files
------------

// File: rtl/voting_pkg.sv
// Shared types and constants for the booth vote scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package voting_pkg;

    localparam int NUM_BOOTHS  = 4;
    localparam int BOOTH_IDX_W = 2;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_OPEN   = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_CLOSED = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        CH_A       = 2'b00,
        CH_B       = 2'b01,
        CH_C       = 2'b10,
        CH_INVALID = 2'b11
    } choice_e;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [NUM_BOOTHS-1:0] booth_onehot(input logic [BOOTH_IDX_W-1:0] idx);
        logic [NUM_BOOTHS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter; priority starts at ptr, ptr moves past each grant.
// Latency: grant is combinational from req; pointer updates on the clock after advance.
// Backpressure: none; caller masks req and asserts advance only when a grant is consumed.
//
// Ports: clk/rst_n  clock and async active-low reset (pointer returns to booth 0)
//        req        per-booth request vector
//        advance    grant consumed this cycle, move pointer past grant_idx
//        grant      one-hot grant (all zero when no request)
//        grant_idx  binary index of grant (0 when no request)
module rr_arbiter_4
    import voting_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             req,
    input  logic                   advance,
    output logic [3:0]             grant,
    output logic [BOOTH_IDX_W-1:0] grant_idx
);

    logic [BOOTH_IDX_W-1:0] ptr;
    logic [BOOTH_IDX_W-1:0] cand;
    logic                   found;

    // Scan the four booths starting at ptr, wrapping via 2-bit arithmetic.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + BOOTH_IDX_W'(k);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/booth_vote_scheduler.sv
// Voting session controller: arbitrates booth requests, streams votes to the tally, acks/nacks booths.
// Latency: selection -> cast_valid or booth_nack next cycle; handshake -> booth_ack next cycle.
// Backpressure: cast held stable while cast_ready is low; no new selection while a cast is pending.
//
// Ports: clk/rst_n            clock, async active-low reset
//        open_req/close_req   one-cycle session control pulses
//        booth_req/choice     per-booth request level and 2-bit choice (booth i at [2i+1:2i])
//        booth_ack/nack       one-cycle per-booth result pulses
//        cast_valid/choice/booth/ready   vote stream to the tally counter
//        state_out, voted_mask, total_votes, reject_count   status
module booth_vote_scheduler #(
    parameter int NUM_BOOTHS = voting_pkg::NUM_BOOTHS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    open_req,
    input  logic                    close_req,
    input  logic [NUM_BOOTHS-1:0]   booth_req,
    input  logic [2*NUM_BOOTHS-1:0] booth_choice,
    output logic [NUM_BOOTHS-1:0]   booth_ack,
    output logic [NUM_BOOTHS-1:0]   booth_nack,
    output logic                    cast_valid,
    output logic [1:0]              cast_choice,
    output logic [1:0]              cast_booth,
    input  logic                    cast_ready,
    output logic [1:0]              state_out,
    output logic [NUM_BOOTHS-1:0]   voted_mask,
    output logic [7:0]              total_votes,
    output logic [7:0]              reject_count
);
    import voting_pkg::*;

    state_e                 state_q;
    state_e                 state_d;
    logic [3:0]             arb_req;
    logic [3:0]             grant;
    logic [BOOTH_IDX_W-1:0] grant_idx;
    logic [1:0]             sel_choice;
    logic                   sel_vld;
    logic                   eligible;
    logic                   launch;
    logic                   reject;
    logic                   handshake;
    logic                   open_entry;

    assign handshake = cast_valid && cast_ready;

    // A booth pulsed this cycle has not yet had a chance to drop its request,
    // so it sits out one round. Nothing is selected while a cast is outstanding.
    assign arb_req = cast_valid ? 4'b0000 : (booth_req & ~(booth_ack | booth_nack));

    rr_arbiter_4 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (arb_req),
        .advance   (sel_vld),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign sel_vld    = |grant;
    assign sel_choice = booth_choice[{grant_idx, 1'b0} +: 2];
    assign eligible   = (state_q == ST_OPEN) && !voted_mask[grant_idx]
                        && (sel_choice != CH_INVALID);
    assign launch     = sel_vld && eligible;
    assign reject     = sel_vld && !eligible;

    // Session FSM. In OPEN an open_req is ignored, so close always wins there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_CLOSED: if (open_req)    state_d = ST_OPEN;
            ST_OPEN:            if (close_req)   state_d = ST_DRAIN;
            ST_DRAIN:           if (!cast_valid) state_d = ST_CLOSED;
            default:            state_d = state_q;
        endcase
    end

    assign open_entry = (state_d == ST_OPEN) && (state_q != ST_OPEN);
    assign state_out  = state_q;

    // Launch and handshake are mutually exclusive (launch needs cast_valid low),
    // which also keeps ack and nack from ever firing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cast_valid   <= 1'b0;
            cast_choice  <= '0;
            cast_booth   <= '0;
            booth_ack    <= '0;
            booth_nack   <= '0;
            voted_mask   <= '0;
            total_votes  <= '0;
            reject_count <= '0;
        end else begin
            booth_ack  <= handshake ? booth_onehot(cast_booth) : '0;
            booth_nack <= reject    ? booth_onehot(grant_idx)  : '0;

            if (launch) begin
                cast_valid  <= 1'b1;
                cast_booth  <= grant_idx;
                cast_choice <= sel_choice;
            end else if (handshake) begin
                cast_valid  <= 1'b0;
            end

            if (open_entry) begin
                voted_mask   <= '0;
                total_votes  <= '0;
                reject_count <= '0;
            end else begin
                if (handshake) begin
                    voted_mask  <= voted_mask | booth_onehot(cast_booth);
                    total_votes <= sat_inc(total_votes);
                end
                if (reject) begin
                    reject_count <= sat_inc(reject_count);
                end
            end
        end
    end

endmodule
